// File: rtl/bcd2bin4digit.sv
// Four-digit BCD to 14-bit binary converter: one multiply-by-ten accumulate per clock.
// Optional digit validation is enabled with the macro BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin4digit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  A,
   input  logic [3:0]  B,
   input  logic [3:0]  C,
   input  logic [3:0]  D,
   output logic        ready,
   output logic [13:0] value,
   output logic        err
);

   typedef enum logic {
      IDLE,
      ACC
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  digitA_q, digitA_d;
   logic [3:0]  digitB_q, digitB_d;
   logic [3:0]  digitC_q, digitC_d;
   logic [3:0]  digitD_q, digitD_d;
   logic [13:0] acc_q, acc_d;
   logic [1:0]  step_q, step_d;
   logic [13:0] value_q, value_d;
   logic [3:0]  curDigit;
   logic [13:0] accSum;
`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic        invalid_q, invalid_d;
   logic        err_q, err_d;
`endif

   // Digits are consumed most significant first so that acc*10 shifts earlier digits up.
   always_comb begin
      curDigit = digitA_q;
      case (step_q)
         2'd0:    curDigit = digitA_q;
         2'd1:    curDigit = digitB_q;
         2'd2:    curDigit = digitC_q;
         default: curDigit = digitD_q;
      endcase
   end

   // acc*10 as (acc<<3)+(acc<<1); bits above 13 fall off, giving modulo-16384 wrap.
   assign accSum = {acc_q[10:0], 3'b000} + {acc_q[12:0], 1'b0} + {10'd0, curDigit};

   always_comb begin
      state_d  = state_q;
      digitA_d = digitA_q;
      digitB_d = digitB_q;
      digitC_d = digitC_q;
      digitD_d = digitD_q;
      acc_d    = acc_q;
      step_d   = step_q;
      value_d  = value_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      invalid_d = invalid_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               digitA_d = A;
               digitB_d = B;
               digitC_d = C;
               digitD_d = D;
               acc_d    = 14'd0;
               step_d   = 2'd0;
               state_d  = ACC;
`ifdef BCD2BIN_DIGIT_CHECK_EN
               invalid_d = (A > 4'd9) || (B > 4'd9) || (C > 4'd9) || (D > 4'd9);
`endif
            end
         end
         default: begin
            if (step_q == 2'd3) begin
               state_d = IDLE;
               acc_d   = accSum;
`ifdef BCD2BIN_DIGIT_CHECK_EN
               value_d = invalid_q ? 14'd0 : accSum;
               err_d   = invalid_q;
`else
               value_d = accSum;
`endif
            end else begin
               acc_d  = accSum;
               step_d = step_q + 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         digitA_q <= 4'd0;
         digitB_q <= 4'd0;
         digitC_q <= 4'd0;
         digitD_q <= 4'd0;
         acc_q    <= 14'd0;
         step_q   <= 2'd0;
         value_q  <= 14'd0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         invalid_q <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         digitA_q <= digitA_d;
         digitB_q <= digitB_d;
         digitC_q <= digitC_d;
         digitD_q <= digitD_d;
         acc_q    <= acc_d;
         step_q   <= step_d;
         value_q  <= value_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         invalid_q <= invalid_d;
         err_q     <= err_d;
`endif
      end
   end

   assign ready = (state_q == IDLE);
   assign value = value_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin4digit.sv
// Self-checking bench for bcd2bin4digit: table-driven conversions plus handshake,
// back-to-back and mid-conversion reset sequences.
module tb_bcd2bin4digit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  A, B, C, D;
   logic        ready;
   logic [13:0] value;
   logic        err;

   int nCompared;
   int nMismatched;

   typedef struct {
      logic [3:0]  a, b, c, d;
      logic [13:0] expValue;
      logic        expErr;
   } vector_t;

   vector_t vectors [9];

   bcd2bin4digit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .ready (ready),
      .value (value),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Presents digits with a one-edge start pulse, then counts busy edges until ready.
   task automatic applyStimulus(input logic [3:0] a, b, c, d, output int busyCycles);
      int n;
      @(negedge clk);
      A = a; B = b; C = c; D = d;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
      checkOutput("ready low after accept", int'(ready), 0);
      n = 0;
      while (ready !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (ready !== 1'b1) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL conversion timeout: ready=%0b after %0d edges, expected 1", ready, n);
      end
      busyCycles = n;
   endtask

   initial begin
      int busy;
      logic [13:0] held;
      nCompared   = 0;
      nMismatched = 0;

      vectors[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 14'd1234, 1'b0};
      vectors[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 1'b0};
      vectors[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 14'd0,    1'b0};
      vectors[3] = '{4'd0, 4'd0, 4'd0, 4'd1, 14'd1,    1'b0};
      vectors[4] = '{4'd9, 4'd0, 4'd0, 4'd0, 14'd9000, 1'b0};
      vectors[5] = '{4'd0, 4'd9, 4'd0, 4'd9, 14'd909,  1'b0};
`ifdef BCD2BIN_DIGIT_CHECK_EN
      vectors[6] = '{4'd15, 4'd15, 4'd15, 4'd15, 14'd0, 1'b1};
      vectors[8] = '{4'd10, 4'd0, 4'd0, 4'd0, 14'd0, 1'b1};
`else
      vectors[6] = '{4'd15, 4'd15, 4'd15, 4'd15, 14'd281, 1'b0};
      vectors[8] = '{4'd10, 4'd0, 4'd0, 4'd0, 14'd10000, 1'b0};
`endif
      vectors[7] = '{4'd0, 4'd0, 4'd1, 4'd0, 14'd10, 1'b0};

      rst = 1'b1; start = 1'b0;
      A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset ready", int'(ready), 1);
      checkOutput("reset value", int'(value), 0);
      checkOutput("reset err", int'(err), 0);
      for (int i = 0; i < 10; i++) begin
         A = 4'(i); B = 4'd9; C = 4'd7; D = 4'(i);
         @(posedge clk);
         #1;
         checkOutput("idle ready", int'(ready), 1);
      end
      checkOutput("idle value", int'(value), 0);
      checkOutput("idle err", int'(err), 0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vectors[i].a, vectors[i].b, vectors[i].c, vectors[i].d, busy);
         checkOutput($sformatf("vec%0d busy cycles", i), busy, 4);
         checkOutput($sformatf("vec%0d value", i), int'(value), int'(vectors[i].expValue));
         checkOutput($sformatf("vec%0d err", i), int'(err), int'(vectors[i].expErr));
         held = value;
         repeat (3) begin
            @(negedge clk);
            A = 4'd3; B = 4'd1; C = 4'd4; D = 4'd1;
         end
         #1;
         checkOutput($sformatf("vec%0d value hold", i), int'(value), int'(held));
      end

      // Busy-time start is dropped, and digit changes during ACC do not leak in.
      @(negedge clk);
      A = 4'd5; B = 4'd6; C = 4'd7; D = 4'd8;
      start = 1'b1;
      @(posedge clk);
      #1;
      A = 4'd1; B = 4'd1; C = 4'd1; D = 4'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         A = 4'(i + 2); B = 4'(i + 5); C = 4'(9 - i); D = 4'(i);
         checkOutput("busy ready low", int'(ready), 0);
         @(posedge clk);
         #1;
      end
      checkOutput("handshake ready", int'(ready), 1);
      checkOutput("handshake value", int'(value), 5678);
      @(posedge clk);
      #1;
      checkOutput("busy start not queued", int'(ready), 1);

      // Start held high: accept every fifth edge.
      @(negedge clk);
      A = 4'd0; B = 4'd0; C = 4'd4; D = 4'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("b2b accept", int'(ready), 0);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("b2b ready edge %0d", i), int'(ready), (i % 5 == 4) ? 1 : 0);
         if (i % 5 == 4) checkOutput("b2b value", int'(value), 42);
      end
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("b2b drain ready", int'(ready), 1);
      checkOutput("b2b drain value", int'(value), 42);

      // Reset on the second ACC edge abandons the conversion and clears the result.
      @(negedge clk);
      A = 4'd4; B = 4'd3; C = 4'd2; D = 4'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("mid reset ready", int'(ready), 1);
      checkOutput("mid reset value", int'(value), 0);
      checkOutput("mid reset err", int'(err), 0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("post reset stays idle", int'(ready), 1);
      checkOutput("post reset value", int'(value), 0);
      applyStimulus(4'd0, 4'd0, 4'd0, 4'd7, busy);
      checkOutput("after reset busy", busy, 4);
      checkOutput("after reset value", int'(value), 7);

      // Reset wins over start on the same edge.
      @(negedge clk);
      A = 4'd9; B = 4'd9; C = 4'd9; D = 4'd9;
      start = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst = 1'b0;
      checkOutput("reset over start ready", int'(ready), 1);
      checkOutput("reset over start value", int'(value), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
